// File: rtl/ysyx_22040895_pcu_pkg.sv
// Shared types and constants for the PC / fetch sequencer.
package ysyx_22040895_pcu_pkg;

    localparam int REG_W  = 64;
    localparam int INST_W = 32;

    localparam logic [REG_W-1:0] PCU_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        PCU_BOOT  = 3'd0,
        PCU_REQ   = 3'd1,
        PCU_WAIT  = 3'd2,
        PCU_HOLD  = 3'd3,
        PCU_DRAIN = 3'd4,
        PCU_HALT  = 3'd5
    } pcu_state_e;

    // Redirect targets are forced to word alignment.
    function automatic logic [REG_W-1:0] align_pc(input logic [REG_W-1:0] addr);
        return {addr[REG_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22040895_pcu.sv
// Program counter and single-outstanding fetch sequencer.
//
// state | meaning
// ------+---------------------------------------------------------------
// BOOT  | one cycle after reset, no bus activity
// REQ   | fetch request valid at the current PC
// WAIT  | request accepted, waiting for the instruction
// HOLD  | instruction buffered and offered to decode
// DRAIN | a stale fetch is outstanding; its response will be discarded
// HALT  | terminal until reset, all handshakes idle
module ysyx_22040895_pcu
    import ysyx_22040895_pcu_pkg::*;
#(
    parameter logic [REG_W-1:0] RESET_PC = PCU_RESET_PC
) (
    input  logic              clk_i_pcu,
    input  logic              rst_n_i_pcu,
    output logic              ifreq_valid_o_pcu,
    input  logic              ifreq_ready_i_pcu,
    output logic [REG_W-1:0]  ifreq_addr_o_pcu,
    input  logic              ifrsp_valid_i_pcu,
    input  logic [INST_W-1:0] ifrsp_inst_i_pcu,
    output logic              ifrsp_ready_o_pcu,
    output logic              inst_valid_o_pcu,
    input  logic              inst_ready_i_pcu,
    output logic [INST_W-1:0] inst_o_pcu,
    output logic [REG_W-1:0]  pc_o_pcu,
    input  logic              redir_valid_i_pcu,
    input  logic [REG_W-1:0]  redir_pc_i_pcu,
    input  logic              halt_i_pcu,
    output logic              flush_o_pcu,
    output logic              halted_o_pcu,
    output logic [REG_W-1:0]  inst_cnt_o_pcu
);

    pcu_state_e        state_q, state_d;
    logic [REG_W-1:0]  pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [REG_W-1:0]  cnt_q, cnt_d;
    logic              flush_q;
    logic              redir_take;

    // Redirects are ignored while booting and once halted.
    assign redir_take = redir_valid_i_pcu && (state_q != PCU_BOOT) && (state_q != PCU_HALT);

    // Register all sequencer state; reset returns to BOOT at RESET_PC.
    always_ff @(posedge clk_i_pcu or negedge rst_n_i_pcu) begin
        if (!rst_n_i_pcu) begin
            state_q <= PCU_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
            flush_q <= redir_take;
        end
    end

    // Next-state, PC, buffer and counter updates; a redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        if (redir_take) begin
            pc_d = align_pc(redir_pc_i_pcu);
        end
        case (state_q)
            PCU_BOOT: state_d = PCU_REQ;
            PCU_REQ: begin
                if (ifreq_ready_i_pcu) begin
                    state_d = redir_take ? PCU_DRAIN : PCU_WAIT;
                end
            end
            PCU_WAIT: begin
                if (redir_take) begin
                    state_d = ifrsp_valid_i_pcu ? PCU_REQ : PCU_DRAIN;
                end else if (ifrsp_valid_i_pcu) begin
                    inst_d  = ifrsp_inst_i_pcu;
                    state_d = PCU_HOLD;
                end
            end
            PCU_HOLD: begin
                if (redir_take) begin
                    state_d = PCU_REQ;
                end else if (inst_ready_i_pcu) begin
                    pc_d    = pc_q + 64'd4;
                    cnt_d   = cnt_q + 64'd1;
                    state_d = halt_i_pcu ? PCU_HALT : PCU_REQ;
                end
            end
            PCU_DRAIN: begin
                if (!redir_take && ifrsp_valid_i_pcu) begin
                    state_d = PCU_REQ;
                end
            end
            PCU_HALT: state_d = PCU_HALT;
            default:  state_d = PCU_BOOT;
        endcase
    end

    assign ifreq_valid_o_pcu = (state_q == PCU_REQ);
    assign ifreq_addr_o_pcu  = pc_q;
    assign ifrsp_ready_o_pcu = (state_q == PCU_WAIT) || (state_q == PCU_DRAIN);
    // A same-cycle redirect squashes the offered instruction.
    assign inst_valid_o_pcu  = (state_q == PCU_HOLD) && !redir_valid_i_pcu;
    assign inst_o_pcu        = inst_q;
    assign pc_o_pcu          = pc_q;
    assign flush_o_pcu       = flush_q;
    assign halted_o_pcu      = (state_q == PCU_HALT);
    assign inst_cnt_o_pcu    = cnt_q;

endmodule

// File: tb/tb_ysyx_22040895_pcu.sv
// Self-checking bench for the PC / fetch sequencer: directed scenarios plus
// randomized traffic against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ysyx_22040895_pcu;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam int P_BOOT = 0, P_REQ = 1, P_WAIT = 2, P_HOLD = 3, P_DRAIN = 4, P_HALT = 5;

    logic        clk;
    logic        rst_n;
    logic        ifreq_valid, ifreq_ready;
    logic [63:0] ifreq_addr;
    logic        ifrsp_valid, ifrsp_ready;
    logic [31:0] ifrsp_inst;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_out;
    logic [63:0] pc_out;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        halt;
    logic        flush, halted;
    logic [63:0] inst_cnt;

    ysyx_22040895_pcu dut (
        .clk_i_pcu         (clk),
        .rst_n_i_pcu       (rst_n),
        .ifreq_valid_o_pcu (ifreq_valid),
        .ifreq_ready_i_pcu (ifreq_ready),
        .ifreq_addr_o_pcu  (ifreq_addr),
        .ifrsp_valid_i_pcu (ifrsp_valid),
        .ifrsp_inst_i_pcu  (ifrsp_inst),
        .ifrsp_ready_o_pcu (ifrsp_ready),
        .inst_valid_o_pcu  (inst_valid),
        .inst_ready_i_pcu  (inst_ready),
        .inst_o_pcu        (inst_out),
        .pc_o_pcu          (pc_out),
        .redir_valid_i_pcu (redir_valid),
        .redir_pc_i_pcu    (redir_pc),
        .halt_i_pcu        (halt),
        .flush_o_pcu       (flush),
        .halted_o_pcu      (halted),
        .inst_cnt_o_pcu    (inst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model
    int          m_ph;
    logic [63:0] m_pc, m_cnt;
    logic [31:0] m_buf;
    logic        m_flush;

    // memory model
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_inst;

    // per-cycle observations for directed scenarios
    logic [63:0] obs_addr[64], obs_pc[64], obs_cnt[64];
    logic        obs_valid[64], obs_rspr[64], obs_ival[64], obs_flush[64], obs_halted[64];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d t=%0t got=%h exp=%h", tag, cyc, $time, got, exp);
        end
    endtask

    task automatic compare_outputs();
        check_val("ifreq_valid", 64'(ifreq_valid), 64'(m_ph == P_REQ));
        check_val("ifreq_addr",  ifreq_addr, m_pc);
        check_val("ifrsp_ready", 64'(ifrsp_ready), 64'((m_ph == P_WAIT) || (m_ph == P_DRAIN)));
        check_val("inst_valid",  64'(inst_valid), 64'((m_ph == P_HOLD) && !redir_valid));
        check_val("inst_o",      64'(inst_out), 64'(m_buf));
        check_val("pc_o",        pc_out, m_pc);
        check_val("flush",       64'(flush), 64'(m_flush));
        check_val("halted",      64'(halted), 64'(m_ph == P_HALT));
        check_val("inst_cnt",    inst_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_ph     = P_BOOT;
        m_pc     = RST_PC;
        m_cnt    = 64'd0;
        m_buf    = 32'd0;
        m_flush  = 1'b0;
        mem_pend = 1'b0;
        mem_cnt  = 0;
        mem_inst = 32'd0;
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    // A redirect lands in DRAIN whenever a fetch is still owed by memory
    // after this cycle, and in REQ otherwise.
    task automatic model_step();
        bit live, take, owed;
        live = (m_ph != P_BOOT) && (m_ph != P_HALT);
        take = live && redir_valid;
        m_flush = take;
        if (m_ph == P_BOOT) begin
            m_ph = P_REQ;
        end else if (take) begin
            m_pc = {redir_pc[63:2], 2'b00};
            owed = ((m_ph == P_REQ) && ifreq_ready) || ((m_ph == P_WAIT) && !ifrsp_valid)
                   || (m_ph == P_DRAIN);
            m_ph = owed ? P_DRAIN : P_REQ;
        end else if (m_ph == P_REQ && ifreq_ready) begin
            m_ph = P_WAIT;
        end else if (m_ph == P_WAIT && ifrsp_valid) begin
            m_buf = ifrsp_inst;
            m_ph  = P_HOLD;
        end else if (m_ph == P_HOLD && inst_ready) begin
            m_pc  = m_pc + 64'd4;
            m_cnt = m_cnt + 64'd1;
            m_ph  = halt ? P_HALT : P_REQ;
        end else if (m_ph == P_DRAIN && ifrsp_valid) begin
            m_ph = P_REQ;
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #3;
        rst_n       = 1'b0;
        ifreq_ready = 1'b0;
        ifrsp_valid = 1'b0;
        ifrsp_inst  = 32'd0;
        inst_ready  = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 64'd0;
        halt        = 1'b0;
        #1;
        model_reset();
        compare_outputs();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    // One clock: drive inputs, compare outputs, update memory and model.
    task automatic cycle(input bit rdy, input int dly, input bit irdy, input bit rv,
                         input logic [63:0] rpc, input bit hlt);
        @(negedge clk);
        ifreq_ready = rdy;
        ifrsp_valid = mem_pend && (mem_cnt == 0);
        ifrsp_inst  = mem_inst;
        inst_ready  = irdy;
        redir_valid = rv;
        redir_pc    = rpc;
        halt        = hlt;
        #1;
        compare_outputs();
        if (cyc < 64) begin
            obs_addr[cyc]   = ifreq_addr;
            obs_pc[cyc]     = pc_out;
            obs_cnt[cyc]    = inst_cnt;
            obs_valid[cyc]  = ifreq_valid;
            obs_rspr[cyc]   = ifrsp_ready;
            obs_ival[cyc]   = inst_valid;
            obs_flush[cyc]  = flush;
            obs_halted[cyc] = halted;
        end
        if (ifrsp_valid && (m_ph == P_WAIT || m_ph == P_DRAIN)) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (m_ph == P_REQ && rdy) begin
            mem_pend = 1'b1;
            mem_cnt  = dly;
            mem_inst = $urandom;
        end
        model_step();
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d t=%0t", cyc, $time);
        $fatal(1, "time limit");
    end

    initial begin
        int s;
        rst_n = 1'b0;
        model_reset();

        // steady fetch with zero-wait memory
        do_reset();
        for (int i = 0; i < 11; i++) cycle(1, 0, 1, 0, 64'd0, 0);
        check_val("t1_req0_valid", 64'(obs_valid[1]), 64'd1);
        check_val("t1_req0_addr",  obs_addr[1], RST_PC);
        check_val("t1_gap_valid",  64'(obs_valid[2] | obs_valid[3]), 64'd0);
        check_val("t1_req1_valid", 64'(obs_valid[4]), 64'd1);
        check_val("t1_req1_addr",  obs_addr[4], RST_PC + 64'd4);
        check_val("t1_req2_valid", 64'(obs_valid[7]), 64'd1);
        check_val("t1_req2_addr",  obs_addr[7], RST_PC + 64'd8);
        check_val("t1_cnt3",       obs_cnt[10], 64'd3);

        // redirect in WAIT with a late response
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1, (i == 1) ? 4 : 0, 1, i == 2, 64'h8000_0100, 0);
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(obs_ival[i]);
        check_val("t2_no_ival", 64'(s), 64'd0);
        s = 0;
        for (int i = 0; i < 10; i++) s += int'(obs_flush[i]);
        check_val("t2_flush_once", 64'(s), 64'd1);
        check_val("t2_flush_c3",   64'(obs_flush[3]), 64'd1);
        check_val("t2_drain_c5",   64'(obs_rspr[5] & ~obs_valid[5]), 64'd1);
        check_val("t2_req_valid",  64'(obs_valid[7]), 64'd1);
        check_val("t2_req_addr",   obs_addr[7], 64'h8000_0100);

        // redirect in HOLD with decode ready in the same cycle
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1, 0, 1, i == 3, 64'h8000_0203, 0);
        check_val("t3_ival_squash", 64'(obs_ival[3]), 64'd0);
        check_val("t3_req_addr",    obs_addr[4], 64'h8000_0200);
        check_val("t3_req_valid",   64'(obs_valid[4]), 64'd1);
        check_val("t3_cnt",         obs_cnt[6], 64'd0);

        // memory stalls for five cycles, redirect mid-stall
        do_reset();
        for (int i = 0; i < 9; i++) cycle(i >= 6, 0, 1, i == 3, 64'h8000_0400, 0);
        s = 0;
        for (int i = 1; i <= 6; i++) s += int'(obs_valid[i]);
        check_val("t4_valid_held", 64'(s), 64'd6);
        check_val("t4_addr_c2",    obs_addr[2], RST_PC);
        check_val("t4_addr_c3",    obs_addr[3], RST_PC);
        check_val("t4_addr_c4",    obs_addr[4], 64'h8000_0400);
        check_val("t4_no_drain",   64'(obs_rspr[4] | obs_rspr[5] | obs_rspr[6]), 64'd0);
        check_val("t4_hs_addr",    obs_addr[6], 64'h8000_0400);
        check_val("t4_wait_c7",    64'(obs_rspr[7]), 64'd1);

        // halt on acceptance, later redirect ignored
        do_reset();
        for (int i = 0; i < 13; i++) cycle(1, 0, 1, i == 6, 64'h8000_0800, i == 3);
        check_val("t5_not_halted", 64'(obs_halted[3]), 64'd0);
        check_val("t5_halted",     64'(obs_halted[4]), 64'd1);
        s = 0;
        for (int i = 4; i <= 12; i++) s += int'(obs_valid[i]) + int'(obs_flush[i]) + int'(obs_rspr[i]);
        check_val("t5_idle",       64'(s), 64'd0);
        check_val("t5_pc_kept",    obs_pc[12], RST_PC + 64'd4);
        check_val("t5_cnt",        obs_cnt[12], 64'd1);

        // reset asserted while waiting for a response
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 3, 1, 0, 64'd0, 0);
        check_val("t6_in_wait", 64'(obs_rspr[2]), 64'd1);
        assert_reset();
        check_val("t6_rst_rspr",  64'(ifrsp_ready), 64'd0);
        check_val("t6_rst_addr",  ifreq_addr, RST_PC);
        release_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0, 64'd0, 0);
        check_val("t6_restart_valid", 64'(obs_valid[1]), 64'd1);
        check_val("t6_restart_addr",  obs_addr[1], RST_PC);

        // PC wraps past the top of the address space
        do_reset();
        for (int i = 0; i < 7; i++) cycle(i != 1, 0, 1, i == 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        check_val("t7_top_addr",  obs_addr[2], 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("t7_wrap_addr", obs_addr[5], 64'd0);
        check_val("t7_wrap_valid", 64'(obs_valid[5]), 64'd1);

        // randomized traffic
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int k = 0; k < 400; k++) begin
                bit          rdy, irdy, rv, hlt;
                int          dly;
                logic [63:0] rpc;
                rdy  = ($urandom % 10) < 7;
                dly  = int'($urandom % 4);
                irdy = ($urandom % 4) != 0;
                rv   = ($urandom % 6) == 0;
                if (m_ph == P_DRAIN && mem_pend && mem_cnt == 0) rv = 1'b0;
                if ($urandom % 4 == 0) rpc = {$urandom, $urandom};
                else rpc = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
                hlt  = (seg >= 3) && (($urandom % 60) == 0);
                cycle(rdy, dly, irdy, rv, rpc, hlt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
